// File: rtl/contador_pkg.sv
// rtl/contador_pkg.sv - shared constants and helpers for the millisecond timer
// Holds count-direction encodings, default parameters and the prescaler width function.
package contador_pkg;

   localparam int DEF_CHANNELS     = 4;
   localparam int DEF_TICKS_PER_MS = 500;
   localparam int DEF_MS_BITS      = 11;

   localparam logic MODE_UP   = 1'b0;
   localparam logic MODE_DOWN = 1'b1;

   function automatic int presc_width(input int ticks);
      return (ticks < 2) ? 1 : $clog2(ticks);
   endfunction

endpackage

// File: rtl/contador_canal.sv
// rtl/contador_canal.sv - one timer channel: prescaler, ms count, sticky flags, snapshot
// Up-count end behaviour selected by CONTADOR_SATURATE_EN (hold at max) or default (wrap).
module contador_canal
   import contador_pkg::*;
#(
   parameter int TICKS_PER_MS = DEF_TICKS_PER_MS,
   parameter int MS_BITS      = DEF_MS_BITS
) (
   input  logic               NEclk,
   input  logic               Nreset,
   input  logic               enable,
   input  logic               clear,
   input  logic               mode,
   input  logic               load,
   input  logic [MS_BITS-1:0] load_value,
   input  logic               latch,
   input  logic               snap_ack,
   output logic [MS_BITS-1:0] ms,
   output logic [MS_BITS-1:0] snap,
   output logic               snap_valid,
   output logic               overflow,
   output logic               done
);

   localparam int               PW         = presc_width(TICKS_PER_MS);
   localparam logic [PW-1:0]    PRESC_LAST = PW'(TICKS_PER_MS - 1);
   localparam logic [MS_BITS-1:0] MS_MAX   = '1;

   logic [PW-1:0]      presc_q, presc_d;
   logic [MS_BITS-1:0] ms_q, ms_d;
   logic [MS_BITS-1:0] snap_q, snap_d;
   logic               snap_valid_q, snap_valid_d;
   logic               overflow_q, overflow_d;
   logic               done_q, done_d;
   logic               tick;

   always_comb begin
      presc_d      = presc_q;
      ms_d         = ms_q;
      overflow_d   = overflow_q;
      done_d       = done_q;
      snap_d       = snap_q;
      snap_valid_d = snap_valid_q;
      tick         = enable && (presc_q == PRESC_LAST);

      if (clear) begin
         ms_d       = '0;
         presc_d    = '0;
         overflow_d = 1'b0;
         done_d     = 1'b0;
      end else if (load) begin
         ms_d       = load_value;
         presc_d    = '0;
         overflow_d = 1'b0;
         done_d     = 1'b0;
      end else if (enable) begin
         presc_d = tick ? '0 : presc_q + PW'(1);
         if (tick) begin
            if (mode == MODE_UP) begin
               if (ms_q == MS_MAX) begin
                  overflow_d = 1'b1;
`ifdef CONTADOR_SATURATE_EN
                  ms_d = MS_MAX;
`else
                  ms_d = '0;
`endif
               end else begin
                  ms_d = ms_q + MS_BITS'(1);
               end
            end else if (ms_q > MS_BITS'(1)) begin
               ms_d = ms_q - MS_BITS'(1);
            end else begin
               // down mode never wraps: 1 -> 0 and 0 holds, both flag done
               ms_d   = '0;
               done_d = 1'b1;
            end
         end
      end

      // snapshot sees the pre-edge count, so it is independent of clear/load above
      if (latch && (!snap_valid_q || snap_ack)) begin
         snap_d       = ms_q;
         snap_valid_d = 1'b1;
      end else if (snap_ack) begin
         snap_valid_d = 1'b0;
      end
   end

   always_ff @(negedge NEclk or negedge Nreset) begin
      if (!Nreset) begin
         presc_q      <= '0;
         ms_q         <= '0;
         snap_q       <= '0;
         snap_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         ms_q         <= ms_d;
         snap_q       <= snap_d;
         snap_valid_q <= snap_valid_d;
         overflow_q   <= overflow_d;
         done_q       <= done_d;
      end
   end

   assign ms         = ms_q;
   assign snap       = snap_q;
   assign snap_valid = snap_valid_q;
   assign overflow   = overflow_q;
   assign done       = done_q;

endmodule

// File: rtl/contador_ms_multi.sv
// rtl/contador_ms_multi.sv - multi-channel millisecond timer top level
// Generates CHANNELS contador_canal instances; CONTADOR_SATURATE_EN selects up-count saturation.
module contador_ms_multi
   import contador_pkg::*;
#(
   parameter int CHANNELS     = DEF_CHANNELS,
   parameter int TICKS_PER_MS = DEF_TICKS_PER_MS,
   parameter int MS_BITS      = DEF_MS_BITS
) (
   input  logic                        NEclk,
   input  logic                        Nreset,
   input  logic [CHANNELS-1:0]         enable,
   input  logic [CHANNELS-1:0]         clear,
   input  logic [CHANNELS-1:0]         mode,
   input  logic [CHANNELS-1:0]         load,
   input  logic [MS_BITS-1:0]          load_value,
   input  logic [CHANNELS-1:0]         latch,
   input  logic [CHANNELS-1:0]         snap_ack,
   output logic [CHANNELS*MS_BITS-1:0] ms,
   output logic [CHANNELS*MS_BITS-1:0] snap,
   output logic [CHANNELS-1:0]         snap_valid,
   output logic [CHANNELS-1:0]         overflow,
   output logic [CHANNELS-1:0]         done
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_canal
      contador_canal #(
         .TICKS_PER_MS (TICKS_PER_MS),
         .MS_BITS      (MS_BITS)
      ) u_canal (
         .NEclk      (NEclk),
         .Nreset     (Nreset),
         .enable     (enable[i]),
         .clear      (clear[i]),
         .mode       (mode[i]),
         .load       (load[i]),
         .load_value (load_value),
         .latch      (latch[i]),
         .snap_ack   (snap_ack[i]),
         .ms         (ms[i*MS_BITS +: MS_BITS]),
         .snap       (snap[i*MS_BITS +: MS_BITS]),
         .snap_valid (snap_valid[i]),
         .overflow   (overflow[i]),
         .done       (done[i])
      );
   end

endmodule

// File: doc/contador_ms_multi.md
# contador_ms_multi

Multi-channel millisecond timer: the parametrised successor of the single counter plus count-to-ms pair. Each of CHANNELS independent channels divides the system clock by TICKS_PER_MS into millisecond ticks and accumulates them, up or down, with its own enable, clear, preload, overflow/done flags and a latched snapshot with a valid/ack handshake. It sits between the system clock and the display/readout logic of the stopwatch design.

## Interface
- CHANNELS, 4, number of independent timer channels
- TICKS_PER_MS, 500, NEclk cycles per millisecond tick (≥ 2)
- MS_BITS, 11, width of each channel's millisecond count
- NEclk  in  1  system clock; all state updates on its falling edge
- Nreset  in  1  asynchronous, active-low reset
- enable  in  CHANNELS  per-channel count enable; the prescaler advances only while high
- clear  in  CHANNELS  synchronous clear of count, prescaler and flags
- mode  in  CHANNELS  0 = count up, 1 = count down
- load  in  CHANNELS  synchronous preload of count from load_value
- load_value  in  MS_BITS  shared preload value
- latch  in  CHANNELS  snapshot request
- snap_ack  in  CHANNELS  snapshot consumed
- ms  out  CHANNELS*MS_BITS  live counts; channel i occupies bits [i*MS_BITS +: MS_BITS]
- snap  out  CHANNELS*MS_BITS  latched counts, same packing
- snap_valid  out  CHANNELS  snapshot held and not yet acknowledged
- overflow  out  CHANNELS  sticky up-count wrap/saturation flag
- done  out  CHANNELS  sticky down-count reached-zero flag

## Operation
- Reset (Nreset low, asynchronous): ms, snap, prescalers, snap_valid, overflow and done are all 0. The block stays in reset until Nreset is released; the first update happens on the first falling edge after release.
- Per-channel priority on each edge: clear > load > count.
  - clear: ms=0, prescaler=0, overflow=0, done=0. snap and snap_valid are unaffected.
  - load: ms=load_value, prescaler=0, overflow=0, done=0.
- Prescaler:
  - When enable=1, it counts 0..TICKS_PER_MS-1 and wraps to 0.
  - A tick occurs on the edge where it wraps.
  - When enable=0, it holds its value. Pausing therefore does not lose a partial millisecond.
- Up mode tick:
  - Normally ms+1.
  - At 2^MS_BITS-1: ms wraps to 0 and overflow is set.
- Down mode tick:
  - Normally ms-1.
  - At ms=1: ms goes to 0 and done is set.
  - At ms=0: ms holds 0 and done is set. Down mode never wraps.
- Changing mode mid-count takes effect on the next tick. Count and prescaler are kept.
- Snapshot handshake:
  - Capture condition: latch=1 and (snap_valid=0 or snap_ack=1).
  - On capture, snap takes the pre-edge value of ms and snap_valid=1.
  - snap_ack=1 without a capture clears snap_valid.
  - latch=1 while snap_valid=1 and snap_ack=0 is ignored, and snap is held.
  - latch together with clear or load captures the pre-edge ms value.
- Channels are fully independent. Simultaneous events on different channels do not interact.

## Timing
- ms changes on the falling edge that completes the TICKS_PER_MS-th enabled cycle. Latency from enable rising to the first tick is exactly TICKS_PER_MS edges.
- clear, load, latch and snap_ack take effect on the first falling edge that samples them. All outputs are registered, with 1-edge latency.
- overflow and done assert on the same edge as the ms transition that causes them. They stay high until clear, load or reset.
- Reset mid-count takes effect immediately, with no edge required.

## Configuration
- CONTADOR_SATURATE_EN
  - Defined: an up-count at 2^MS_BITS-1 holds at 2^MS_BITS-1 instead of wrapping. overflow is still set.
  - Undefined: wrap to 0 as described above.
- Down-mode behaviour is identical in both builds.

## Structure
- Package contador_pkg holds:
  - MODE_UP/MODE_DOWN constants
  - the prescaler width function, $clog2(TICKS_PER_MS)
  - the default parameter values
- Sub-module contador_canal implements one channel: prescaler, count, flags and snapshot. The top level generates CHANNELS instances and packs the buses.

## Test plan
All scenarios use TICKS_PER_MS=4, MS_BITS=4 and CHANNELS=2.
- Enable ch0 up for 20 edges -> ms0=5 at edge 20; ch1 disabled stays 0; overflow0=0.
- Enable 6 edges, disable 10, enable 2 -> ms0=2 (partial ms kept across the pause).
- Up count through 15 -> wraps to 0 with overflow0=1. With CONTADOR_SATURATE_EN defined it holds 15 with overflow0=1. clear -> ms0=0 and overflow0=0.
- load 3 in down mode and count 16 edges -> 2,1,0 then holds 0; done0=1 from the edge reaching 0.
- latch at ms0=7 -> snap0=7 and snap_valid0=1. latch again at 9 with no ack -> snap0 stays 7. latch+ack at 11 -> snap0=11 and snap_valid0=1. ack alone -> snap_valid0=0.
- Pulse Nreset low between edges mid-count -> all outputs 0 immediately. After release the first tick comes after 4 enabled edges.
